// File: rtl/divider_sequencer.sv
// -----------------------------------------------------------------------------
// divider_sequencer
//
// Run-control and configuration sequencer for a modulo-N clock divider.
// A WIDTH-bit counter steps through 0..term. The block produces a tick
// pulse on the last count of every period and a divided output that
// toggles once per period. The controller starts, stops or bursts the
// divider on command. A new terminal count is staged in a pending slot and
// only takes effect at a period boundary, so a period is never cut short.
//
// Ports
//   clk        in   1        system clock, rising edge
//   reset      in   1        synchronous active-high reset
//   cfg_valid  in   1        new terminal count offered
//   cfg_term   in   WIDTH    offered terminal count (0 gives period 1)
//   cfg_ready  out  1        pending slot free; transfer on cfg_valid&cfg_ready
//   start      in   1        begin a run (only acted on while idle)
//   burst_len  in   BURST_W  ticks to produce, sampled with start; 0 = forever
//   stop       in   1        graceful stop request (only acted on in RUN)
//   busy       out  1        high in RUN or STOPPING
//   state      out  WIDTH    current counter value
//   tick       out  1        high while count equals the active term and busy
//   out        out  1        divided output, toggles at the end of each tick
//   done       out  1        one-cycle pulse on the first idle cycle after a run
// -----------------------------------------------------------------------------
module divider_sequencer #(
  parameter int WIDTH        = 3,
  parameter int DEFAULT_TERM = 5,
  parameter int BURST_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  input  logic [WIDTH-1:0]   cfg_term,
  output logic               cfg_ready,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               stop,
  output logic               busy,
  output logic [WIDTH-1:0]   state,
  output logic               tick,
  output logic               out,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } fsm_t;

  fsm_t               fsm;
  logic [WIDTH-1:0]   count;
  logic [WIDTH-1:0]   term;
  logic [WIDTH-1:0]   pend_term;
  logic               pend_valid;
  logic [BURST_W-1:0] burst_cnt;
  logic               out_q;
  logic               done_q;

  logic               cfg_accept;
  logic               final_tick;

  // Handshake, tick and the "this tick ends the run" decision are all
  // derived from registered state. A run ends on a tick either because the
  // burst counter is on its last tick or because a stop is already pending.
  always_comb begin
    busy       = (fsm != IDLE);
    tick       = busy && (count == term);
    cfg_ready  = ~pend_valid;
    cfg_accept = cfg_valid && ~pend_valid;
    final_tick = tick && ((burst_cnt == BURST_W'(1)) || (fsm == STOPPING));
  end

  assign state = count;
  assign out   = out_q;
  assign done  = done_q;

  // Single sequential block for the FSM, counter, divided output and the
  // configuration slot. While idle the pending term is applied on the very
  // next edge; a term offered together with start bypasses the slot so the
  // first period already uses it. While busy the pending term only lands on
  // the wrap edge, so the term can never change in the middle of a period.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= IDLE;
      count      <= '0;
      term       <= WIDTH'(DEFAULT_TERM);
      pend_term  <= '0;
      pend_valid <= 1'b0;
      burst_cnt  <= '0;
      out_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm)
        IDLE: begin
          count <= '0;
          if (pend_valid) begin
            term       <= pend_term;
            pend_valid <= 1'b0;
          end else if (cfg_accept && start) begin
            term <= cfg_term;
          end else if (cfg_accept) begin
            pend_term  <= cfg_term;
            pend_valid <= 1'b1;
          end
          if (start) begin
            fsm       <= RUN;
            out_q     <= 1'b0;
            burst_cnt <= burst_len;
          end
        end
        default: begin
          if (tick) begin
            count <= '0;
            out_q <= ~out_q;
            if (burst_cnt != '0) begin
              burst_cnt <= burst_cnt - BURST_W'(1);
            end
            if (pend_valid) begin
              term       <= pend_term;
              pend_valid <= 1'b0;
            end
          end else begin
            count <= count + WIDTH'(1);
          end
          // Accept is only possible with the slot empty, so it never
          // collides with the apply above.
          if (cfg_accept) begin
            pend_term  <= cfg_term;
            pend_valid <= 1'b1;
          end
          if (final_tick) begin
            fsm    <= IDLE;
            done_q <= 1'b1;
          end else if ((fsm == RUN) && stop) begin
            fsm <= STOPPING;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// -----------------------------------------------------------------------------
// tb_divider_sequencer
//
// Self-checking bench for divider_sequencer. A behavioural model tracks the
// divider as a handful of integers (running / stop requested / ticks left /
// count / term / pending term) and every output is compared each cycle.
// Directed scenarios come first, followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_divider_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic [2:0] cfg_term;
  logic       cfg_ready;
  logic       start;
  logic [3:0] burst_len;
  logic       stop;
  logic       busy;
  logic [2:0] state;
  logic       tick;
  logic       out;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;
  int tick_seen   = 0;

  // Reference model state
  bit m_busy, m_stop_req, m_out, m_done, m_pend_v;
  int m_count, m_term, m_pend, m_left;

  divider_sequencer #(
    .WIDTH(3),
    .DEFAULT_TERM(5),
    .BURST_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_term(cfg_term),
    .cfg_ready(cfg_ready),
    .start(start),
    .burst_len(burst_len),
    .stop(stop),
    .busy(busy),
    .state(state),
    .tick(tick),
    .out(out),
    .done(done)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report it when observed differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag,
               observed, expected, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  // Decisions are made from the values before the edge, then committed.
  task automatic model_step();
    bit m_tick;
    bit accept;
    bit finish;
    if (reset) begin
      m_busy = 0; m_stop_req = 0; m_out = 0; m_done = 0; m_pend_v = 0;
      m_count = 0; m_term = 5; m_pend = 0; m_left = 0;
      return;
    end
    m_tick = m_busy && (m_count == m_term);
    accept = cfg_valid && !m_pend_v;
    finish = 0;
    m_done = 0;
    if (!m_busy) begin
      m_count = 0;
      if (m_pend_v) begin
        m_term = m_pend; m_pend_v = 0;
      end else if (accept && start) begin
        m_term = int'(cfg_term);
      end else if (accept) begin
        m_pend = int'(cfg_term); m_pend_v = 1;
      end
      if (start) begin
        m_busy = 1; m_stop_req = 0; m_out = 0; m_left = int'(burst_len);
      end
    end else begin
      if (m_tick) begin
        m_count = 0;
        m_out = !m_out;
        if (m_left != 0) begin
          m_left--;
          if (m_left == 0) finish = 1;
        end
        if (m_stop_req) finish = 1;
        if (m_pend_v) begin
          m_term = m_pend; m_pend_v = 0;
        end
      end else begin
        m_count++;
      end
      if (accept) begin
        m_pend = int'(cfg_term); m_pend_v = 1;
      end
      if (finish) begin
        m_busy = 0; m_done = 1;
      end else if (stop) begin
        m_stop_req = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, step the model on the rising edge and check
  // every output on the following falling edge.
  task automatic applyStimulus(input bit r, input bit cv, input int ct,
                               input bit st, input int bl, input bit sp);
    reset     = r;
    cfg_valid = cv;
    cfg_term  = 3'(ct);
    start     = st;
    burst_len = 4'(bl);
    stop      = sp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("state", 32'(state), 32'(m_count));
    checkOutput("tick", 32'(tick), 32'(m_busy && (m_count == m_term)));
    checkOutput("out", 32'(out), 32'(m_out));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("cfg_ready", 32'(cfg_ready), 32'(!m_pend_v));
    if (tick === 1'b1) tick_seen++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Continuous run with the default term: ticks at cycles 5, 11, 17
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick_seen = 0;
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle_cycles(17);
    checkOutput("cont_ticks", 32'(tick_seen), 32'd3);

    // Burst of three ticks, then done and out left high
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick_seen = 0;
    applyStimulus(0, 0, 0, 1, 3, 0);
    idle_cycles(25);
    checkOutput("burst_ticks", 32'(tick_seen), 32'd3);
    checkOutput("burst_out", 32'(out), 32'd1);

    // Reconfigure to term 2 while counting at 1
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle_cycles(1);
    applyStimulus(0, 1, 2, 0, 0, 0);
    idle_cycles(15);

    // Stop at count 2, with extra stop/start pulses that must be ignored
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle_cycles(2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    idle_cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle_cycles(6);
    checkOutput("stop_idle", 32'(busy), 32'd0);

    // Term 0: tick held high and out toggling every cycle
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idle_cycles(1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle_cycles(6);

    // Config accepted together with start is used from the first period
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0);
    idle_cycles(6);

    // Reset in the middle of a run at count 4
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle_cycles(4);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    idle_cycles(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, cv, st, sp;
      int ct, bl;
      r  = ($urandom_range(99) == 0);
      cv = ($urandom_range(3) == 0);
      ct = $urandom_range(7);
      st = ($urandom_range(5) == 0);
      bl = ($urandom_range(1) == 0) ? 0 : $urandom_range(1, 6);
      sp = ($urandom_range(15) == 0);
      applyStimulus(r, cv, ct, st, bl, sp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
